// File: rtl/flag_branch_unit_pkg.sv
// Shared constants for the flag branch unit: op codes, FSM states, widths and
// the branch-condition helper used by the control logic.
package flag_branch_unit_pkg;

   localparam int unsigned DataWidth  = 16;
   localparam int unsigned CountWidth = 8;

   typedef enum logic [1:0] {
      OpBlt = 2'b00,  // taken if flag is TRUE (nonzero)
      OpBge = 2'b01,  // taken if flag is FALSE (zero)
      OpJmp = 2'b10,  // always taken
      OpNop = 2'b11   // never taken
   } op_e;

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StEval    = 2'b01,
      StHold    = 2'b10,
      StIllegal = 2'b11
   } state_e;

   // Any nonzero flag pattern is TRUE.
   function automatic logic branch_taken(input op_e op, input logic [DataWidth-1:0] flag);
      logic flag_true;
      flag_true = |flag;
      unique case (op)
         OpBlt:   branch_taken = flag_true;
         OpBge:   branch_taken = ~flag_true;
         OpJmp:   branch_taken = 1'b1;
         default: branch_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/FullAdder2s_16bit.sv
// 16-bit two's-complement adder with carry-in; the result wraps modulo 2^16.
module FullAdder2s_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum
);

   // Carry-out is intentionally dropped: wrap-around is the defined behaviour.
   always_comb begin
      sum = a + b + {15'd0, cin};
   end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag-driven branch resolver: accepts one request, evaluates the branch
// condition, then holds the resolved next_pc until the consumer takes it.
module flag_branch_unit
   import flag_branch_unit_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            op,
   input  logic [DataWidth-1:0]  flag,
   input  logic [DataWidth-1:0]  pc,
   input  logic [DataWidth-1:0]  offset,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  taken,
   output logic [DataWidth-1:0]  next_pc,
   output logic [CountWidth-1:0] taken_count
);

   state_e                state_q;
   op_e                   op_q;
   logic [DataWidth-1:0]  flag_q;
   logic [DataWidth-1:0]  pc_q;
   logic [DataWidth-1:0]  offset_q;
   logic                  taken_q;
   logic [DataWidth-1:0]  next_pc_q;
   logic [CountWidth-1:0] count_q;
   logic                  in_ready_q;
   logic                  out_valid_q;

   logic                  eval_taken;
   logic [DataWidth-1:0]  add_b;
   logic [DataWidth-1:0]  add_sum;

   // Branch decision and adder operand select from the captured request.
   always_comb begin
      eval_taken = branch_taken(op_q, flag_q);
      add_b      = eval_taken ? offset_q : '0;
   end

   // Single adder: pc + (taken ? offset : 0) + 1, the +1 arrives via carry-in.
   FullAdder2s_16bit u_adder (
      .a   (pc_q),
      .b   (add_b),
      .cin (1'b1),
      .sum (add_sum)
   );

   // Control FSM with registered handshake and result outputs.
   // in_ready is registered so it reads 0 in reset and rises one edge later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         op_q        <= OpBlt;
         flag_q      <= '0;
         pc_q        <= '0;
         offset_q    <= '0;
         taken_q     <= 1'b0;
         next_pc_q   <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_ready_q && in_valid) begin
                  op_q       <= op_e'(op);
                  flag_q     <= flag;
                  pc_q       <= pc;
                  offset_q   <= offset;
                  in_ready_q <= 1'b0;
                  state_q    <= StEval;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            StEval: begin
               taken_q     <= eval_taken;
               next_pc_q   <= add_sum;
               out_valid_q <= 1'b1;
               state_q     <= StHold;
            end
            StHold: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
                  if (taken_q && (count_q != '1)) begin
                     count_q <= count_q + 8'd1;
                  end
               end
            end
            default: begin
               // Illegal encoding: recover to IDLE, ready is re-raised from there.
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               state_q     <= StIdle;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign taken       = taken_q;
   assign next_pc     = next_pc_q;
   assign taken_count = count_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed cases plus randomized
// requests checked against an arithmetic reference model.
module tb_flag_branch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [15:0] flag;
   logic [15:0] pc;
   logic [15:0] offset;
   logic        out_valid;
   logic        out_ready;
   logic        taken;
   logic [15:0] next_pc;
   logic [7:0]  taken_count;

   int n_vec     = 0;
   int n_fail    = 0;
   int model_cnt = 0;
   int cyc       = 0;

   flag_branch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op          (op),
      .flag        (flag),
      .pc          (pc),
      .offset      (offset),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .taken       (taken),
      .next_pc     (next_pc),
      .taken_count (taken_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: decision from the op table, address by signed integer arithmetic.
   function automatic void ref_model(input logic [1:0] o, input logic [15:0] f,
                                     input logic [15:0] p, input logic [15:0] off,
                                     output logic t, output logic [15:0] npc);
      int target;
      case (o)
         2'd0:    t = (f != 16'd0);
         2'd1:    t = (f == 16'd0);
         2'd2:    t = 1'b1;
         default: t = 1'b0;
      endcase
      target = int'(p) + 1 + (t ? int'($signed(off)) : 0);
      npc    = 16'(target);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int w;
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (in_ready !== 1'b1) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
   endtask

   // One full transaction; out_ready is held low for `hold` clocks in HOLD.
   task automatic run_req(input logic [1:0] o, input logic [15:0] f, input logic [15:0] p,
                          input logic [15:0] off, input int hold, output int acc_cyc);
      logic        t;
      logic [15:0] npc;
      ref_model(o, f, p, off, t, npc);
      wait_ready();
      op = o; flag = f; pc = p; offset = off;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(negedge clk);
      acc_cyc = cyc;
      chk("eval_out_valid", {31'd0, out_valid}, 32'd0);
      chk("eval_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_taken", {31'd0, taken}, {31'd0, t});
      chk("hold_next_pc", {16'd0, next_pc}, {16'd0, npc});
      for (int i = 0; i < hold; i++) begin
         // Garbage request while busy must be ignored.
         in_valid = 1'b1; op = ~o; pc = ~p; flag = ~f;
         @(negedge clk);
         chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_taken", {31'd0, taken}, {31'd0, t});
         chk("stall_next_pc", {16'd0, next_pc}, {16'd0, npc});
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (t && model_cnt < 255) model_cnt++;
      @(negedge clk);
      chk("done_out_valid", {31'd0, out_valid}, 32'd0);
      chk("done_in_ready", {31'd0, in_ready}, 32'd1);
      chk("done_count", {24'd0, taken_count}, model_cnt);
   endtask

   initial begin
      int acc;
      int prev_acc;
      logic [1:0]  r_op;
      logic [15:0] r_flag;

      // Reset with a request pending: it must be discarded.
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      op = 2'd2; flag = 16'h0; pc = 16'h0100; offset = 16'h0010;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_next_pc", {16'd0, next_pc}, 32'd0);
      chk("rst_count", {24'd0, taken_count}, 32'd0);
      repeat (2) @(negedge clk);
      chk("rst_in_ready_held", {31'd0, in_ready}, 32'd0);
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

      // Directed cases: BLT high flag bit, BGE with pc wrap, JMP negative with stall, NOP.
      run_req(2'd0, 16'h8000, 16'h0010, 16'h0005, 0, acc);
      run_req(2'd1, 16'h0001, 16'hFFFF, 16'h0003, 0, acc);
      run_req(2'd2, 16'h0000, 16'h0004, 16'hFFFB, 4, acc);
      run_req(2'd3, 16'hFFFF, 16'h1234, 16'h0007, 0, acc);
      run_req(2'd1, 16'h0000, 16'h7FFF, 16'h8000, 1, acc);

      // Randomized requests, zero flag favoured to exercise both conditions.
      for (int i = 0; i < 40; i++) begin
         r_op   = 2'($urandom_range(0, 3));
         r_flag = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
         run_req(r_op, r_flag, 16'($urandom), 16'($urandom), $urandom_range(0, 2), acc);
      end

      // Reset while holding a result, with in_valid asserted throughout.
      run_req(2'd2, 16'h0, 16'h0020, 16'h0001, 0, acc);
      wait_ready();
      op = 2'd2; pc = 16'h0040; offset = 16'h0002; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_hold_valid", {31'd0, out_valid}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_taken", {31'd0, taken}, 32'd0);
      chk("midrst_next_pc", {16'd0, next_pc}, 32'd0);
      chk("midrst_count", {24'd0, taken_count}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      model_cnt = 0;
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_delivery_after_rst", {31'd0, out_valid}, 32'd0);
      end

      // 260 back-to-back JMPs: count saturates, one request every 3 clocks.
      run_req(2'd2, 16'h0, 16'h0000, 16'h0001, 0, prev_acc);
      for (int i = 1; i < 260; i++) begin
         run_req(2'd2, 16'h0, 16'(i), 16'h0001, 0, acc);
         chk("b2b_spacing", acc - prev_acc, 32'd3);
         prev_acc = acc;
      end
      chk("sat_count", {24'd0, taken_count}, 32'hFF);

      // NOP after saturation leaves the count alone.
      run_req(2'd3, 16'hFFFF, 16'h1234, 16'h0000, 0, acc);
      chk("nop_count_sat", {24'd0, taken_count}, 32'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset; the port list SHALL be as below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 in_valid  input  1  request present on op/flag/pc/offset.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  2  00 BLT (taken if flag != 0), 01 BGE (taken if flag == 0), 10 JMP (always taken), 11 NOP (never taken).
REQ-007 flag  input  16  comparator flag; 16'h0000 = FALSE, any nonzero = TRUE.
REQ-008 pc  input  16  address of the branch instruction.
REQ-009 offset  input  16  signed two's-complement word offset.
REQ-010 out_valid  output  1  result valid on taken/next_pc.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 taken  output  1  branch decision.
REQ-013 next_pc  output  16  resolved next address.
REQ-014 taken_count  output  8  saturating count of taken results delivered.

Function
REQ-015 The FSM SHALL have three states: IDLE=00, EVAL=01, HOLD=10; 11 is illegal and SHALL go to IDLE on the next clock.
REQ-016 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid & in_ready are both high at a clock edge.
REQ-017 On acceptance, op, flag, pc and offset SHALL be registered and the FSM SHALL move to EVAL.
REQ-018 In EVAL the block SHALL compute taken from the registered op and flag per REQ-006, register taken and next_pc, and move to HOLD.
REQ-019 When taken, next_pc SHALL be pc + 1 + offset, truncated to 16 bits (wraps modulo 2^16, no overflow flag).
REQ-020 When not taken, next_pc SHALL be pc + 1, truncated to 16 bits; pc = 16'hFFFF SHALL give 16'h0000.
REQ-021 out_valid SHALL be 1 only in HOLD; latency is 2 clocks from the accepting edge to out_valid high.
REQ-022 taken and next_pc SHALL stay stable while out_valid is high and out_ready is low.
REQ-023 In HOLD with out_ready high, the result SHALL be delivered at that edge and the FSM SHALL return to IDLE; the earliest next acceptance is the following edge (one request per 3 clocks maximum).
REQ-024 taken_count SHALL increment by 1 on each delivered result with taken=1, and SHALL saturate at 8'hFF.
REQ-025 in_valid while not in IDLE SHALL be ignored; the upstream block holds the request until in_ready.
REQ-026 Any nonzero flag bit pattern, including 16'h0001 and 16'h8000, SHALL count as TRUE.

Reset
REQ-027 Asserting reset at any time, including in EVAL or HOLD, SHALL at once set state=IDLE, out_valid=0, taken=0, next_pc=16'h0000, taken_count=8'h00 and clear all captured registers.
REQ-028 in_ready SHALL read 0 while reset is high and 1 on the first clock edge after reset is released.
REQ-029 A request pending during reset SHALL be discarded, not delivered.

Structure
REQ-030 The op encodings and FSM state encodings SHALL be defined once in a shared constants package or header that the ALU and control blocks also use.
REQ-031 The pc + 1 + offset and pc + 1 additions SHALL use one instance of the existing FullAdder2s_16bit sub-module, with operands muxed and carry-in driving the +1; no other sub-module is needed.

Verification
REQ-032 BLT, flag=16'h8000, pc=16'h0010, offset=16'h0005 -> out_valid on edge 2, taken=1, next_pc=16'h0016.
REQ-033 BGE, flag=16'h0001, pc=16'hFFFF, offset=16'h0003 -> taken=0, next_pc=16'h0000 (wrap).
REQ-034 JMP, pc=16'h0004, offset=16'hFFFB (-5) -> taken=1, next_pc=16'h0000; then hold out_ready=0 for 4 clocks -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next clock.
REQ-035 Reset in HOLD with out_valid=1 -> out_valid=0, next_pc=0, taken_count=0 at once; no delivery after reset is released.
REQ-036 260 back-to-back JMP requests with out_ready tied high -> taken_count=8'hFF, no wrap, one delivery every 3 clocks.
REQ-037 NOP with flag=16'hFFFF, pc=16'h1234 -> taken=0, next_pc=16'h1235, taken_count unchanged.
